// File: rtl/affine_pkg.sv
// Shared definitions for the affine stream engine: config register map and CTRL bit positions.
package affine_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_A      = 4'd1;
    localparam logic [3:0] ADDR_B      = 4'd2;
    localparam logic [3:0] ADDR_D      = 4'd3;
    localparam logic [3:0] ADDR_E      = 4'd4;
    localparam logic [3:0] ADDR_TX     = 4'd5;
    localparam logic [3:0] ADDR_TY     = 4'd6;
    localparam logic [3:0] ADDR_THRESH = 4'd7;
    localparam logic [3:0] ADDR_STATUS = 4'd8;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

endpackage

// File: rtl/affine_sfifo.sv
// Generic show-ahead synchronous FIFO with occupancy count and synchronous flush.
module affine_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/affine_stream_pipe.sv
// Streaming 2-D affine transform: 3-stage multiply/round/translate pipeline feeding a credit-managed output FIFO.
// Build option AFFINE_SATURATE_EN: overflowing results clamp to the signed range instead of wrapping.
module affine_stream_pipe
    import affine_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FRAC_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic              out_ovf,
    output logic              irq
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = PW + 2;
    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC_W - 1);

    typedef struct packed {
        logic              ovf;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] x;
    } point_t;

    logic                     en, irq_en, ovf_sticky;
    logic signed [DATA_W-1:0] coef_a, coef_b, coef_d, coef_e, coef_tx, coef_ty;
    logic [CNT_W-1:0]         thresh;
    logic                     flush, accept, busy;

    logic signed [PW-1:0]     s1_ax, s1_by, s1_dx, s1_ey;
    logic signed [DATA_W-1:0] s1_tx, s1_ty, s2_tx, s2_ty;
    logic signed [SW-1:0]     s2_x, s2_y, sum_x, sum_y;
    logic signed [RW-1:0]     r_x, r_y;
    logic [DATA_W:0]          f_x, f_y;
    logic                     s1_v, s2_v, s3_v;
    point_t                   s3_pt, head;

    logic signed [PW-1:0]     ext_a, ext_b, ext_d, ext_e, ext_x, ext_y;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full, fifo_empty;
    logic [1:0]               inflight;
    logic [CNT_W:0]           occupancy;

    // Range check plus wrap or clamp of a full-precision result to DATA_W bits; returns {ovf, value}.
    function automatic logic [DATA_W:0] fit(input logic signed [RW-1:0] r);
        logic              ovf;
        logic [DATA_W-1:0] v;
        ovf = !((&r[RW-1:DATA_W-1]) || !(|r[RW-1:DATA_W-1]));
`ifdef AFFINE_SATURATE_EN
        if (ovf) v = r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else     v = r[DATA_W-1:0];
`else
        v = r[DATA_W-1:0];
`endif
        return {ovf, v};
    endfunction

    assign flush  = cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_FLUSH];
    assign accept = in_valid && in_ready;
    assign busy   = s1_v || s2_v || s3_v;

    // Credit scheme: every in-flight point already owns a FIFO slot, so the pipeline never stalls.
    assign inflight  = 2'(s1_v) + 2'(s2_v) + 2'(s3_v);
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
    assign in_ready  = en && !fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            coef_a     <= '0;
            coef_b     <= '0;
            coef_d     <= '0;
            coef_e     <= '0;
            coef_tx    <= '0;
            coef_ty    <= '0;
            thresh     <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_CTRL: begin
                        en     <= cfg_wdata[CTRL_EN];
                        irq_en <= cfg_wdata[CTRL_IRQ_EN];
                    end
                    ADDR_A:      coef_a  <= cfg_wdata;
                    ADDR_B:      coef_b  <= cfg_wdata;
                    ADDR_D:      coef_d  <= cfg_wdata;
                    ADDR_E:      coef_e  <= cfg_wdata;
                    ADDR_TX:     coef_tx <= cfg_wdata;
                    ADDR_TY:     coef_ty <= cfg_wdata;
                    ADDR_THRESH: thresh  <= cfg_wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (s3_v && s3_pt.ovf && !flush)
                ovf_sticky <= 1'b1;
            else if (cfg_we && cfg_addr == ADDR_STATUS)
                ovf_sticky <= 1'b0;
        end
    end

    assign ext_a = PW'(coef_a);
    assign ext_b = PW'(coef_b);
    assign ext_d = PW'(coef_d);
    assign ext_e = PW'(coef_e);
    assign ext_x = PW'($signed(in_x));
    assign ext_y = PW'($signed(in_y));

    assign sum_x = SW'(s1_ax) + SW'(s1_by) + RND;
    assign sum_y = SW'(s1_dx) + SW'(s1_ey) + RND;
    assign r_x   = RW'(s2_x) + RW'(s2_tx);
    assign r_y   = RW'(s2_y) + RW'(s2_ty);
    assign f_x   = fit(r_x);
    assign f_y   = fit(r_y);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    always_ff @(posedge clk) begin
        s1_ax <= ext_a * ext_x;
        s1_by <= ext_b * ext_y;
        s1_dx <= ext_d * ext_x;
        s1_ey <= ext_e * ext_y;
        s1_tx <= coef_tx;
        s1_ty <= coef_ty;
        s2_x  <= sum_x >>> FRAC_W;
        s2_y  <= sum_y >>> FRAC_W;
        s2_tx <= s1_tx;
        s2_ty <= s1_ty;
        s3_pt <= '{ovf: f_x[DATA_W] | f_y[DATA_W], y: f_y[DATA_W-1:0], x: f_x[DATA_W-1:0]};
    end

    affine_sfifo #(
        .WIDTH ($bits(point_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (s3_v),
        .wdata (s3_pt),
        .pop   (out_valid && out_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_ovf   = out_valid && head.ovf;
    assign irq       = irq_en && (thresh != '0) && (fifo_count >= thresh);

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_CTRL: begin
                cfg_rdata[CTRL_EN]     = en;
                cfg_rdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_A:      cfg_rdata = coef_a;
            ADDR_B:      cfg_rdata = coef_b;
            ADDR_D:      cfg_rdata = coef_d;
            ADDR_E:      cfg_rdata = coef_e;
            ADDR_TX:     cfg_rdata = coef_tx;
            ADDR_TY:     cfg_rdata = coef_ty;
            ADDR_THRESH: cfg_rdata[CNT_W-1:0] = thresh;
            ADDR_STATUS: begin
                cfg_rdata[CNT_W-1:0] = fifo_count;
                cfg_rdata[CNT_W]     = ovf_sticky;
                cfg_rdata[CNT_W+1]   = busy;
            end
            default: ;
        endcase
    end

endmodule
